// File: rtl/byte_unstrip.sv
// -----------------------------------------------------------------------------
// byte_unstrip
//   RX-side lane merger, the inverse of the TX byte striper. Lane 0 carries the
//   even words and lane 1 carries the odd words of the original stream. Each lane
//   feeds its own small FIFO. A two-state reader pops lane 0 and then lane 1, in
//   strict alternation, and rebuilds one ordered stream at one word per cycle.
//   If lane 1 stalls for longer than SKEW_MAX cycles, the reader flags a skew
//   error and resynchronises to lane 0. No buffered data is discarded.
//
// Ports
//   clk_2f      in   single clock, rising edge
//   reset_L     in   asynchronous, active-low reset
//   lane_0      in   WIDTH  even word
//   valid_0     in   lane_0 holds a word this cycle
//   lane_1      in   WIDTH  odd word
//   valid_1     in   lane_1 holds a word this cycle
//   data_out    out  WIDTH  merged word, 0 when valid_out=0 (registered)
//   valid_out   out  data_out is a merged word (registered)
//   overflow_0  out  sticky, a lane 0 word was dropped because FIFO 0 was full
//   overflow_1  out  sticky, a lane 1 word was dropped because FIFO 1 was full
//   skew_err    out  sticky, lane 1 exceeded the SKEW_MAX wait
// -----------------------------------------------------------------------------
module byte_unstrip #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int SKEW_MAX = 8
) (
    input  logic             clk_2f,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] lane_0,
    input  logic             valid_0,
    input  logic [WIDTH-1:0] lane_1,
    input  logic             valid_1,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             overflow_0,
    output logic             overflow_1,
    output logic             skew_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SKW_W = $clog2(SKEW_MAX + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [SKW_W-1:0] SKEW_LAST = SKW_W'(SKEW_MAX - 1);

    typedef enum logic {WAIT_L0 = 1'b0, WAIT_L1 = 1'b1} state_t;

    logic [WIDTH-1:0] mem0 [DEPTH];
    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [PTR_W-1:0] wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;
    logic [CNT_W-1:0] cnt0, cnt1;
    logic [SKW_W-1:0] skew_cnt, skew_cnt_nxt;
    state_t           state, state_nxt;

    logic             pop0, pop1, push0, push1;
    logic             drop0, drop1, skew_hit;
    logic [WIDTH-1:0] dout_nxt;
    logic             vout_nxt;

    // A full FIFO still takes a push when it pops in the same cycle, because
    // the pop decision is made on the pre-edge count.
    assign push0 = valid_0 && ((cnt0 != FULL_CNT) || pop0);
    assign push1 = valid_1 && ((cnt1 != FULL_CNT) || pop1);
    assign drop0 = valid_0 && !push0;
    assign drop1 = valid_1 && !push1;

    // ---- FIFO storage (data only, not reset) ----
    always_ff @(posedge clk_2f) begin
        if (push0) mem0[wr_ptr0] <= lane_0;
        if (push1) mem1[wr_ptr1] <= lane_1;
    end

    // ---- FIFO pointers, counts and overflow flags ----
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr0    <= '0;
            rd_ptr0    <= '0;
            wr_ptr1    <= '0;
            rd_ptr1    <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
            overflow_0 <= 1'b0;
            overflow_1 <= 1'b0;
        end else begin
            if (push0) wr_ptr0 <= wr_ptr0 + PTR_W'(1);
            if (pop0)  rd_ptr0 <= rd_ptr0 + PTR_W'(1);
            if (push1) wr_ptr1 <= wr_ptr1 + PTR_W'(1);
            if (pop1)  rd_ptr1 <= rd_ptr1 + PTR_W'(1);
            if (push0 && !pop0)      cnt0 <= cnt0 + CNT_W'(1);
            else if (pop0 && !push0) cnt0 <= cnt0 - CNT_W'(1);
            if (push1 && !pop1)      cnt1 <= cnt1 + CNT_W'(1);
            else if (pop1 && !push1) cnt1 <= cnt1 - CNT_W'(1);
            if (drop0) overflow_0 <= 1'b1;
            if (drop1) overflow_1 <= 1'b1;
        end
    end

    // ---- Reader FSM: next state and output word ----
    always_comb begin
        state_nxt    = state;
        pop0         = 1'b0;
        pop1         = 1'b0;
        dout_nxt     = '0;
        vout_nxt     = 1'b0;
        skew_cnt_nxt = skew_cnt;
        skew_hit     = 1'b0;
        case (state)
            WAIT_L0: begin
                if (cnt0 != '0) begin
                    pop0         = 1'b1;
                    dout_nxt     = mem0[rd_ptr0];
                    vout_nxt     = 1'b1;
                    skew_cnt_nxt = '0;
                    state_nxt    = WAIT_L1;
                end
            end
            WAIT_L1: begin
                if (cnt1 != '0) begin
                    pop1         = 1'b1;
                    dout_nxt     = mem1[rd_ptr1];
                    vout_nxt     = 1'b1;
                    skew_cnt_nxt = '0;
                    state_nxt    = WAIT_L0;
                end else if (skew_cnt == SKEW_LAST) begin
                    // This empty cycle is the SKEW_MAX-th one, so give up on
                    // lane 1 and resync to lane 0. Buffered words are kept.
                    skew_hit     = 1'b1;
                    skew_cnt_nxt = '0;
                    state_nxt    = WAIT_L0;
                end else begin
                    skew_cnt_nxt = skew_cnt + SKW_W'(1);
                end
            end
            default: state_nxt = WAIT_L0;
        endcase
    end

    // ---- Reader FSM: registered state and outputs ----
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= WAIT_L0;
            skew_cnt  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            skew_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            skew_cnt  <= skew_cnt_nxt;
            data_out  <= dout_nxt;
            valid_out <= vout_nxt;
            if (skew_hit) skew_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_byte_unstrip.sv
// -----------------------------------------------------------------------------
// tb_byte_unstrip
//   Directed bench for byte_unstrip (WIDTH=32, DEPTH=4, SKEW_MAX=8). Each
//   step() drives one cycle of lane inputs, waits for the rising edge and then
//   samples 1 ns later. Expected values are worked out by hand per cycle.
// -----------------------------------------------------------------------------
module tb_byte_unstrip;

    logic        clk_2f;
    logic        reset_L;
    logic [31:0] lane_0, lane_1;
    logic        valid_0, valid_1;
    logic [31:0] data_out;
    logic        valid_out, overflow_0, overflow_1, skew_err;

    int n_checks;
    int n_fail;

    byte_unstrip #(.WIDTH(32), .DEPTH(4), .SKEW_MAX(8)) dut (
        .clk_2f     (clk_2f),
        .reset_L    (reset_L),
        .lane_0     (lane_0),
        .valid_0    (valid_0),
        .lane_1     (lane_1),
        .valid_1    (valid_1),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .overflow_0 (overflow_0),
        .overflow_1 (overflow_1),
        .skew_err   (skew_err)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] d);
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
        check({tag, ".data"}, data_out, d);
    endtask

    task automatic expect_flags(input string tag, input logic o0, input logic o1, input logic sk);
        check({tag, ".flags"}, {29'd0, overflow_0, overflow_1, skew_err}, {29'd0, o0, o1, sk});
    endtask

    task automatic step(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
        valid_0 = v0;
        lane_0  = d0;
        valid_1 = v1;
        lane_1  = d1;
        @(posedge clk_2f);
        #1;
        valid_0 = 1'b0;
        lane_0  = '0;
        valid_1 = 1'b0;
        lane_1  = '0;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        expect_out("rst", 1'b0, 32'h0);
        expect_flags("rst", 1'b0, 1'b0, 1'b0);
        @(posedge clk_2f);
        #1;
        reset_L = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        valid_0  = 1'b0;
        valid_1  = 1'b0;
        lane_0   = '0;
        lane_1   = '0;
        reset_L  = 1'b0;
        #3;
        do_reset();

        // 1. Alternation A0,B0,A1,B1
        step(1'b1, 32'hA000_0000, 1'b0, 32'h0);
        expect_out("alt.c0", 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'hB000_0000);
        expect_out("alt.c1", 1'b1, 32'hA000_0000);
        step(1'b1, 32'hA000_0001, 1'b0, 32'h0);
        expect_out("alt.c2", 1'b1, 32'hB000_0000);
        step(1'b0, 32'h0, 1'b1, 32'hB000_0001);
        expect_out("alt.c3", 1'b1, 32'hA000_0001);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("alt.c4", 1'b1, 32'hB000_0001);

        // 2. Lane 1 arrives before lane 0
        do_reset();
        step(1'b0, 32'h0, 1'b1, 32'h22);
        expect_out("early.c0", 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("early.c1", 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("early.c2", 1'b0, 32'h0);
        step(1'b1, 32'h11, 1'b0, 32'h0);
        expect_out("early.c3", 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("early.c4", 1'b1, 32'h11);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("early.c5", 1'b1, 32'h22);

        // 3. Lane 0 overflow: w5 is dropped, w1..w4 interleave with lane 1
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h3000_0000 + i, 1'b0, 32'h0);
            if (i == 1) expect_out("ovf.w0", 1'b1, 32'h3000_0000);
            else        expect_out($sformatf("ovf.c%0d", i), 1'b0, 32'h0);
            if (i == 4) expect_flags("ovf.c4", 1'b0, 1'b0, 1'b0);
        end
        expect_flags("ovf.c5", 1'b1, 1'b0, 1'b0);
        begin
            logic [31:0] exp_d [9];
            exp_d = '{32'h0, 32'h4000_0000, 32'h3000_0001, 32'h4000_0001, 32'h3000_0002,
                      32'h4000_0002, 32'h3000_0003, 32'h4000_0003, 32'h3000_0004};
            for (int i = 0; i < 9; i++) begin
                if (i < 4) step(1'b0, 32'h0, 1'b1, 32'h4000_0000 + i);
                else       step(1'b0, 32'h0, 1'b0, 32'h0);
                expect_out($sformatf("ovf.c%0d", i + 6), (i != 0), exp_d[i]);
            end
        end
        expect_flags("ovf.end", 1'b1, 1'b0, 1'b0);

        // 4. Skew: lane 1 never arrives
        do_reset();
        step(1'b1, 32'h5555_0000, 1'b0, 32'h0);
        expect_out("skew.c0", 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("skew.c1", 1'b1, 32'h5555_0000);
        for (int i = 2; i <= 9; i++) begin
            step(1'b0, 32'h0, 1'b0, 32'h0);
            expect_out($sformatf("skew.c%0d", i), 1'b0, 32'h0);
            if (i == 8) expect_flags("skew.c8", 1'b0, 1'b0, 1'b0);
        end
        expect_flags("skew.c9", 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h5555_0001, 1'b0, 32'h0);
        expect_out("skew.c10", 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("skew.c11", 1'b1, 32'h5555_0001);
        expect_flags("skew.end", 1'b0, 1'b0, 1'b1);

        // 5. Full FIFO 1 pushed while popping: accepted, no overflow
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 32'h6000_0000 + i);
        expect_out("full.fill", 1'b0, 32'h0);
        step(1'b1, 32'h7000_0000, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("full.c5", 1'b1, 32'h7000_0000);
        step(1'b1, 32'h7000_0001, 1'b1, 32'h6000_0004);
        expect_out("full.c6", 1'b1, 32'h6000_0000);
        expect_flags("full.c6", 1'b0, 1'b0, 1'b0);
        begin
            logic [31:0] exp_d [8];
            exp_d = '{32'h7000_0001, 32'h6000_0001, 32'h7000_0002, 32'h6000_0002,
                      32'h7000_0003, 32'h6000_0003, 32'h7000_0004, 32'h6000_0004};
            for (int i = 0; i < 8; i++) begin
                if (i < 3) step(1'b1, 32'h7000_0002 + i, 1'b0, 32'h0);
                else       step(1'b0, 32'h0, 1'b0, 32'h0);
                expect_out($sformatf("full.c%0d", i + 7), 1'b1, exp_d[i]);
            end
        end
        expect_flags("full.end", 1'b0, 1'b0, 1'b0);

        // 6. Asynchronous reset mid-stream with both FIFOs partly full
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 32'h8000_0000 + i);
        expect_flags("mid.ovf", 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h9000_0000, 1'b0, 32'h0);
        step(1'b1, 32'h9000_0001, 1'b0, 32'h0);
        expect_out("mid.q0", 1'b1, 32'h9000_0000);
        step(1'b1, 32'h9000_0002, 1'b0, 32'h0);
        expect_out("mid.p0", 1'b1, 32'h8000_0000);
        #2;
        reset_L = 1'b0;
        #1;
        expect_out("mid.async", 1'b0, 32'h0);
        expect_flags("mid.async", 1'b0, 1'b0, 1'b0);
        @(posedge clk_2f);
        #1;
        reset_L = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0, 32'h0);
            expect_out($sformatf("mid.idle%0d", i), 1'b0, 32'h0);
        end
        step(1'b1, 32'hC000_0000, 1'b1, 32'hC000_0001);
        expect_out("mid.r.c0", 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("mid.r.c1", 1'b1, 32'hC000_0000);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("mid.r.c2", 1'b1, 32'hC000_0001);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        expect_out("mid.r.c3", 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
